// File: rtl/np_portable_top.sv
// NinPortable boot-and-report: reads NUM_BYTES from SPI flash (cmd 0x03), shows each on LED, sends it on UART.
// Define NP_ECHO_EN to add a UART receiver that echoes bytes to SERIAL_TX and LED once the boot is done.
module np_portable_top #(
  parameter logic [23:0] FLASH_ADDR   = 24'h100000,
  parameter int unsigned NUM_BYTES    = 16,
  parameter int unsigned CLKS_PER_BIT = 106
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [7:0] LED,
  input  logic       SERIAL_RX,
  output logic       SERIAL_TX,
  output logic       FLASH_CSB,
  output logic       FLASH_CLK,
  inout  wire        FLASH_IO0,
  inout  wire        FLASH_IO1,
  inout  wire        FLASH_IO2,
  inout  wire        FLASH_IO3
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [15:0] NumBytes = 16'(NUM_BYTES);

  typedef enum logic [2:0] {StStart, StCmd, StRdByte, StTx, StDone} state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [31:0]       cmd_sr_q, cmd_sr_d;
  logic [6:0]        rd_sr_q, rd_sr_d;
  logic [7:0]        led_q, led_d;
  logic              tx_q, tx_d;
  logic [8:0]        tx_sr_q, tx_sr_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [15:0]       count_q, count_d;
  logic              csb_q, csb_d;
  logic              fclk_q, fclk_d;
  logic              io0_q, io0_d;
  logic [7:0]        rd_byte;

  assign rd_byte = {rd_sr_q, FLASH_IO1};

`ifdef NP_ECHO_EN
  localparam logic [BaudW-1:0] RxHalf = BaudW'(CLKS_PER_BIT / 2);

  logic              rx_s1_q, rx_s2_q;
  logic              rx_busy_q, rx_busy_d;
  logic [BaudW-1:0]  rx_baud_q, rx_baud_d;
  logic [3:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              booted_q;
  logic              echo_take;

  assign echo_take = (state_q == StDone) && hold_valid_q;

  always_comb begin
    rx_busy_d    = rx_busy_q;
    rx_baud_d    = rx_baud_q;
    rx_bit_d     = rx_bit_q;
    rx_sr_d      = rx_sr_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q & ~echo_take;
    if (!rx_busy_q) begin
      if (!rx_s2_q) begin
        rx_busy_d = 1'b1;
        rx_baud_d = '0;
        rx_bit_d  = 4'd0;
      end
    end else if ((rx_bit_q == 4'd0) ? (rx_baud_q == RxHalf) : (rx_baud_q == BaudLast)) begin
      rx_baud_d = '0;
      if (rx_bit_q == 4'd0) begin
        // Line back high at mid start bit: glitch, not a frame
        if (rx_s2_q) rx_busy_d = 1'b0;
        else         rx_bit_d  = 4'd1;
      end else if (rx_bit_q == 4'd9) begin
        rx_busy_d = 1'b0;
        if (rx_s2_q && booted_q) begin
          hold_d       = rx_sr_q;
          hold_valid_d = 1'b1;
        end
      end else begin
        rx_sr_d  = {rx_s2_q, rx_sr_q[7:1]};
        rx_bit_d = rx_bit_q + 4'd1;
      end
    end else begin
      rx_baud_d = rx_baud_q + BaudW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_busy_q    <= 1'b0;
      rx_baud_q    <= '0;
      rx_bit_q     <= 4'd0;
      rx_sr_q      <= 8'h00;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      booted_q     <= 1'b0;
    end else begin
      rx_s1_q      <= SERIAL_RX;
      rx_s2_q      <= rx_s1_q;
      rx_busy_q    <= rx_busy_d;
      rx_baud_q    <= rx_baud_d;
      rx_bit_q     <= rx_bit_d;
      rx_sr_q      <= rx_sr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      booted_q     <= booted_q | (state_q == StDone);
    end
  end
`else
  logic unused_serial_rx;
  assign unused_serial_rx = SERIAL_RX;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_sr_d = cmd_sr_q;
    rd_sr_d  = rd_sr_q;
    led_d    = led_q;
    tx_d     = tx_q;
    tx_sr_d  = tx_sr_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    count_d  = count_q;
    csb_d    = csb_q;
    fclk_d   = fclk_q;
    io0_d    = io0_q;
    unique case (state_q)
      StStart: begin
        csb_d    = 1'b0;
        cmd_sr_d = {8'h03, FLASH_ADDR};
        cnt_d    = 6'd0;
        state_d  = StCmd;
      end
      StCmd: begin
        cnt_d = cnt_q + 6'd1;
        if (!cnt_q[0]) begin
          fclk_d   = 1'b0;
          io0_d    = cmd_sr_q[31];
          cmd_sr_d = {cmd_sr_q[30:0], 1'b0};
        end else begin
          fclk_d = 1'b1;
          if (cnt_q == 6'd63) begin
            cnt_d   = 6'd0;
            state_d = StRdByte;
          end
        end
      end
      StRdByte: begin
        cnt_d = cnt_q + 6'd1;
        if (!cnt_q[0]) begin
          fclk_d = 1'b0;
          io0_d  = 1'b0;
        end else begin
          // Sample MISO on the edge that raises FLASH_CLK
          fclk_d  = 1'b1;
          rd_sr_d = rd_byte[6:0];
          if (cnt_q[3:0] == 4'd15) begin
            led_d   = rd_byte;
            count_d = count_q + 16'd1;
            tx_d    = 1'b0;
            tx_sr_d = {1'b1, rd_byte};
            baud_d  = '0;
            bit_d   = 4'd0;
            state_d = StTx;
          end
        end
      end
      StTx: begin
        // Flash clock parked low; CSB stays asserted so the read resumes at the next address
        fclk_d = 1'b0;
        if (baud_q == BaudLast) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            cnt_d = 6'd0;
            if (count_q < NumBytes) begin
              state_d = StRdByte;
            end else begin
              csb_d   = 1'b1;
              io0_d   = 1'b0;
              state_d = StDone;
            end
          end else begin
            tx_d    = tx_sr_q[0];
            tx_sr_d = {1'b1, tx_sr_q[8:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StDone: begin
        csb_d  = 1'b1;
        fclk_d = 1'b0;
        io0_d  = 1'b0;
`ifdef NP_ECHO_EN
        if (echo_take) begin
          led_d   = hold_q;
          tx_d    = 1'b0;
          tx_sr_d = {1'b1, hold_q};
          baud_d  = '0;
          bit_d   = 4'd0;
          state_d = StTx;
        end
`endif
      end
      default: state_d = StStart;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StStart;
      cnt_q    <= 6'd0;
      cmd_sr_q <= 32'h0;
      rd_sr_q  <= 7'h0;
      led_q    <= 8'h00;
      tx_q     <= 1'b1;
      tx_sr_q  <= 9'h1ff;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      count_q  <= 16'd0;
      csb_q    <= 1'b1;
      fclk_q   <= 1'b0;
      io0_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_sr_q <= cmd_sr_d;
      rd_sr_q  <= rd_sr_d;
      led_q    <= led_d;
      tx_q     <= tx_d;
      tx_sr_q  <= tx_sr_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      count_q  <= count_d;
      csb_q    <= csb_d;
      fclk_q   <= fclk_d;
      io0_q    <= io0_d;
    end
  end

  assign LED       = led_q;
  assign SERIAL_TX = tx_q;
  assign FLASH_CSB = csb_q;
  assign FLASH_CLK = fclk_q;
  assign FLASH_IO0 = io0_q;
  // FLASH_IO1 is input-only here and left undriven (hi-Z)
  assign FLASH_IO2 = 1'b1;
  assign FLASH_IO3 = 1'b1;

endmodule

// File: tb/tb_np_portable_top.sv
// Bench for np_portable_top: SPI flash model, UART monitor and expected-stream model.
module tb_np_portable_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_rx = 1'b1;
  logic [7:0] led;
  logic       serial_tx, flash_csb, flash_clk;
  wire        flash_io0, flash_io1, flash_io2, flash_io3;
  logic       miso = 1'b1;

  assign flash_io1 = miso;

  always #5 clk = ~clk;

  np_portable_top dut (
    .CLK       (clk),
    .RST       (rst),
    .LED       (led),
    .SERIAL_RX (serial_rx),
    .SERIAL_TX (serial_tx),
    .FLASH_CSB (flash_csb),
    .FLASH_CLK (flash_clk),
    .FLASH_IO0 (flash_io0),
    .FLASH_IO1 (flash_io1),
    .FLASH_IO2 (flash_io2),
    .FLASH_IO3 (flash_io3)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: byte k of a boot is mem[k]; flash content starts at 0x100000
  logic [7:0] mem [32];
  int         exp_idx = 0;
  int         n_abort = 0;
  logic [7:0] last_rx = 8'h00;
  logic       chk_en = 1'b0;

  // SPI flash (mode 0): command in on rising edges, data out on falling edges
  int          fbits = 0;
  logic [31:0] fcmd = 32'h0;
  int          fdata_bit;
  int          foff;
  logic [7:0]  fbyte;

  always @(posedge flash_csb) fbits = 0;

  always @(posedge flash_clk) begin
    if (!flash_csb) begin
      if (fbits < 32) fcmd = {fcmd[30:0], flash_io0};
      fbits++;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csb && fbits >= 32) begin
      fdata_bit = fbits - 32;
      foff = int'(fcmd[23:0]) - 32'h100000 + fdata_bit / 8;
      fbyte = (foff >= 0 && foff < 32) ? mem[foff] : 8'hff;
      miso = fbyte[7 - (fdata_bit % 8)];
    end
  end

  // Per-cycle pin invariants
  always @(negedge clk) begin
    if (chk_en) begin
      check("io2 high", 32'(flash_io2), 32'd1);
      check("io3 high", 32'(flash_io3), 32'd1);
      if (flash_csb) begin
        check("fclk idle while deselected", 32'(flash_clk), 32'd0);
        check("io0 idle while deselected", 32'(flash_io0), 32'd0);
      end
    end
  end

  // UART monitor and compare against the expected stream
  initial begin : uart_mon
    logic [7:0] b;
    logic       stopb;
    forever begin
      @(negedge serial_tx);
      #1;
      if (!rst) begin
        check("led at start bit", 32'(led), 32'(mem[exp_idx % 32]));
        repeat (53) @(posedge clk);
        #1;
        if (serial_tx !== 1'b0) begin
          n_abort++;
        end else begin
          for (int i = 0; i < 8; i++) begin
            repeat (106) @(posedge clk);
            #1;
            b[i] = serial_tx;
          end
          repeat (106) @(posedge clk);
          #1;
          stopb = serial_tx;
          check("uart byte", 32'(b), 32'(mem[exp_idx % 32]));
          check("uart stop bit", 32'(stopb), 32'd1);
          last_rx = b;
          exp_idx++;
        end
      end
    end
  end

  task automatic wait_idx(input int target, input int budget, input string name);
    int c = 0;
    while (exp_idx < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(name, 32'(exp_idx >= target), 32'd1);
  endtask

  initial begin : main
    logic ok;
    logic tx_idle_ok;
    logic fclk_idle_ok;
    for (int i = 0; i < 32; i++) mem[i] = 8'h41 + 8'(i);

    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset led", 32'(led), 32'h00);
    check("reset tx", 32'(serial_tx), 32'd1);
    check("reset csb", 32'(flash_csb), 32'd1);
    check("reset fclk", 32'(flash_clk), 32'd0);
    check("reset io0", 32'(flash_io0), 32'd0);

    // Boot 1: stream 'A','B','C',...
    rst = 1'b0;
    repeat (79) @(posedge clk);
    #1;
    check("led not yet valid", 32'(led), 32'h00);
    check("csb asserted", 32'(flash_csb), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("led first byte", 32'(led), 32'h41);
    check("cmd byte 0", 32'(fcmd[31:24]), 32'h03);
    check("cmd byte 1", 32'(fcmd[23:16]), 32'h10);
    check("cmd byte 2", 32'(fcmd[15:8]), 32'h00);
    check("cmd byte 3", 32'(fcmd[7:0]), 32'h00);

    wait_idx(1, 1500, "byte 0 received");
    check("first uart char", 32'(last_rx), 32'h41);
    wait_idx(3, 3500, "three bytes received");
    check("third uart char", 32'(last_rx), 32'h43);

    // Reset during byte 3's start bit
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (serial_tx == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("byte 3 start bit seen", 32'(ok), 32'd1);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid reset csb", 32'(flash_csb), 32'd1);
    check("mid reset tx", 32'(serial_tx), 32'd1);
    check("mid reset fclk", 32'(flash_clk), 32'd0);
    check("mid reset led", 32'(led), 32'h00);
    repeat (4) @(posedge clk);
    #1;

    // Boot 2: stream 0x00..0x0F
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    exp_idx = 0;
    fcmd = 32'h0;
    rst = 1'b0;
    wait_idx(1, 1500, "reboot byte 0 received");
    check("reboot first char", 32'(last_rx), 32'h00);
    check("reboot cmd", fcmd, 32'h03100000);
    wait_idx(16, 17500, "sixteen bytes received");
    repeat (100) @(posedge clk);
    #1;
    check("done csb", 32'(flash_csb), 32'd1);
    check("done led", 32'(led), 32'h0f);

    tx_idle_ok = 1'b1;
    fclk_idle_ok = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      if (serial_tx !== 1'b1) tx_idle_ok = 1'b0;
      if (flash_clk !== 1'b0) fclk_idle_ok = 1'b0;
    end
    check("tx idle after done", 32'(tx_idle_ok), 32'd1);
    check("fclk idle after done", 32'(fclk_idle_ok), 32'd1);
    check("no extra bytes", 32'(exp_idx), 32'd16);
    check("only reset frame aborted", 32'(n_abort), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
